// File: rtl/frame_pkg.sv
//------------------------------------------------------------------------------
// Module  : frame_pkg
// Purpose : Shared types and constants for the frame_renderer layer. Holds
//           the config field codes, attr bit positions, game_state codes and
//           the frame descriptor record.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package frame_pkg;

  // Config port field selectors; codes 6 and 7 are unused and ignored
  typedef enum logic [2:0] {
    FLD_X0   = 3'd0,
    FLD_X1   = 3'd1,
    FLD_Y0   = 3'd2,
    FLD_Y1   = 3'd3,
    FLD_ATTR = 3'd4,
    FLD_MASK = 3'd5
  } cfg_field_e;

  // attr word layout
  localparam int ATTR_THICK_LSB = 0;
  localparam int ATTR_THICK_W   = 3;
  localparam int ATTR_COLOR_LSB = 3;
  localparam int ATTR_COLOR_W   = 3;
  localparam int ATTR_BLINK_BIT = 6;
  localparam int ATTR_FILL_BIT  = 7;

  // Game state codes, used as bit indices into state_mask
  typedef enum logic [3:0] {
    STATE_LOGO  = 4'b0000,
    STATE_MENU  = 4'b0001,
    STATE_PLAY  = 4'b0010,
    STATE_PAUSE = 4'b0011,
    STATE_OVER  = 4'b0100
  } game_state_e;

  // Coordinates are held at config-bus width; writes zero-extend the
  // truncated field so the upper bits are always zero.
  typedef struct packed {
    logic [15:0] x0;
    logic [15:0] x1;
    logic [15:0] y0;
    logic [15:0] y1;
    logic [7:0]  attr;
    logic [15:0] state_mask;
  } frame_desc_t;

endpackage

`default_nettype wire

// File: rtl/frame_renderer_hit.sv
//------------------------------------------------------------------------------
// Module  : frame_hit
// Purpose : Combinational hit test of one pixel against one rectangular
//           frame. Reports whether the pixel is inside the rectangle and
//           whether it lies on the border band of width max(thick,1).
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module frame_hit #(
  parameter int X_W     = 11,
  parameter int Y_W     = 10,
  parameter int THICK_W = 3
) (
  input  logic [X_W-1:0]     i_x,
  input  logic [Y_W-1:0]     i_y,
  input  logic [X_W-1:0]     i_x0,
  input  logic [X_W-1:0]     i_x1,
  input  logic [Y_W-1:0]     i_y0,
  input  logic [Y_W-1:0]     i_y1,
  input  logic [THICK_W-1:0] i_thick,
  output logic               o_inside,
  output logic               o_border
);

  logic [THICK_W-1:0] w_t;
  logic [X_W:0]       w_x0_t;
  logic [X_W:0]       w_x_t;
  logic [Y_W:0]       w_y0_t;
  logic [Y_W:0]       w_y_t;
  logic               w_edge;

  // One extra bit on the sums keeps x+t / x0+t from wrapping at the
  // top of the coordinate range. An inverted rectangle fails "inside".
  always_comb begin
    w_t      = (i_thick == '0) ? THICK_W'(1) : i_thick;
    w_x0_t   = {1'b0, i_x0} + (X_W+1)'(w_t);
    w_x_t    = {1'b0, i_x}  + (X_W+1)'(w_t);
    w_y0_t   = {1'b0, i_y0} + (Y_W+1)'(w_t);
    w_y_t    = {1'b0, i_y}  + (Y_W+1)'(w_t);
    o_inside = (i_x >= i_x0) && (i_x <= i_x1) &&
               (i_y >= i_y0) && (i_y <= i_y1);
    w_edge   = ({1'b0, i_x} < w_x0_t) || (w_x_t > {1'b0, i_x1}) ||
               ({1'b0, i_y} < w_y0_t) || (w_y_t > {1'b0, i_y1});
    o_border = o_inside && w_edge;
  end

endmodule

`default_nettype wire

// File: rtl/frame_renderer.sv
//------------------------------------------------------------------------------
// Module  : frame_renderer
// Purpose : Draws NUM_FRAMES configurable rectangular borders into the VGA
//           pixel pipeline. Descriptors are written into shadow registers
//           and copied to the active set at pixel (0,0), so a frame never
//           tears. Fixed two-cycle latency from (x,y) to RGB/dav.
//           Build option FRAME_FILL_EN: frames with attr fill set also paint
//           their interior in inverted colour, below all border hits.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module frame_renderer
  import frame_pkg::*;
#(
  parameter int NUM_FRAMES   = 4,
  parameter int X_W          = 11,
  parameter int Y_W          = 10,
  parameter int COLOR_W      = 3,
  parameter int THICK_W      = 3,
  parameter int BLINK_PERIOD = 30
) (
  input  logic                          vga_clk,
  input  logic                          rst_n,
  input  logic [X_W-1:0]                x,
  input  logic [Y_W-1:0]                y,
  input  logic [3:0]                    game_state,
  input  logic                          cfg_we,
  input  logic [$clog2(NUM_FRAMES)-1:0] cfg_idx,
  input  logic [2:0]                    cfg_field,
  input  logic [15:0]                   cfg_wdata,
  output logic [COLOR_W-1:0]            RGB,
  output logic                          dav,
  output logic                          frame_start
);

  localparam int IDX_W   = $clog2(NUM_FRAMES);
  localparam int BLINK_W = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;

  frame_desc_t r_shadow [NUM_FRAMES];
  frame_desc_t r_active [NUM_FRAMES];
  logic        r_pending;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic        r_blink_phase;

  logic w_origin;
  logic w_cfg_valid;
  logic w_commit;

  logic [NUM_FRAMES-1:0] w_border;
  logic [NUM_FRAMES-1:0] w_fill;
  logic [NUM_FRAMES-1:0] w_inside;
  logic [NUM_FRAMES-1:0] w_unused_desc;
  logic [COLOR_W-1:0]    w_color [NUM_FRAMES];

  logic [NUM_FRAMES-1:0] r_s1_border;
  logic [NUM_FRAMES-1:0] r_s1_fill;
  logic [COLOR_W-1:0]    r_s1_color [NUM_FRAMES];
  logic                  r_s1_origin;

  logic                  w_any;
  logic [COLOR_W-1:0]    w_win;
  logic                  w_unused;

  assign w_origin    = (x == '0) && (y == '0);
  assign w_cfg_valid = cfg_we && (cfg_field <= FLD_MASK) &&
                       ({1'b0, cfg_idx} < (IDX_W+1)'(NUM_FRAMES));
  assign w_commit    = w_origin && r_pending;

  // Shadow register file and pending flag; a write in the commit cycle wins
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_FRAMES; i++) r_shadow[i] <= '0;
      r_pending <= 1'b0;
    end else begin
      if (w_cfg_valid) begin
        r_pending <= 1'b1;
        case (cfg_field)
          FLD_X0:   r_shadow[cfg_idx].x0 <= 16'(cfg_wdata[X_W-1:0]);
          FLD_X1:   r_shadow[cfg_idx].x1 <= 16'(cfg_wdata[X_W-1:0]);
          FLD_Y0:   r_shadow[cfg_idx].y0 <= 16'(cfg_wdata[Y_W-1:0]);
          FLD_Y1:   r_shadow[cfg_idx].y1 <= 16'(cfg_wdata[Y_W-1:0]);
          FLD_ATTR: r_shadow[cfg_idx].attr <= cfg_wdata[7:0];
          default:  r_shadow[cfg_idx].state_mask <= cfg_wdata;
        endcase
      end else if (w_commit) begin
        r_pending <= 1'b0;
      end
    end
  end

  // Atomic copy of every shadow descriptor into the active set at (0,0)
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_FRAMES; i++) r_active[i] <= '0;
    end else if (w_commit) begin
      for (int i = 0; i < NUM_FRAMES; i++) r_active[i] <= r_shadow[i];
    end
  end

  // Blink timebase: counts video frames, toggles phase every BLINK_PERIOD
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (w_origin) begin
      if (r_blink_cnt == BLINK_W'(BLINK_PERIOD - 1)) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
      end
    end
  end

  generate
    for (genvar g = 0; g < NUM_FRAMES; g++) begin : g_frame
      logic w_vis;
      logic w_in;
      logic w_bd;

      frame_hit #(
        .X_W     (X_W),
        .Y_W     (Y_W),
        .THICK_W (THICK_W)
      ) u_hit (
        .i_x      (x),
        .i_y      (y),
        .i_x0     (r_active[g].x0[X_W-1:0]),
        .i_x1     (r_active[g].x1[X_W-1:0]),
        .i_y0     (r_active[g].y0[Y_W-1:0]),
        .i_y1     (r_active[g].y1[Y_W-1:0]),
        .i_thick  (THICK_W'(r_active[g].attr[ATTR_THICK_LSB +: ATTR_THICK_W])),
        .o_inside (w_in),
        .o_border (w_bd)
      );

      assign w_vis = r_active[g].state_mask[game_state] &&
                     !(r_active[g].attr[ATTR_BLINK_BIT] && r_blink_phase);
      assign w_border[g] = w_bd && w_vis;
      assign w_inside[g] = w_in;
`ifdef FRAME_FILL_EN
      assign w_fill[g] = w_in && !w_bd && w_vis && r_active[g].attr[ATTR_FILL_BIT];
`else
      assign w_fill[g] = 1'b0;
`endif
      assign w_color[g] = COLOR_W'(r_active[g].attr[ATTR_COLOR_LSB +: ATTR_COLOR_W]);
      assign w_unused_desc[g] = ^r_active[g];
    end
  endgenerate

  assign w_unused = ^{w_unused_desc, w_inside, r_s1_fill};

  // Stage 1: register per-frame hit vectors, colours and the origin marker
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_border <= '0;
      r_s1_fill   <= '0;
      r_s1_origin <= 1'b0;
      for (int i = 0; i < NUM_FRAMES; i++) r_s1_color[i] <= '0;
    end else begin
      r_s1_border <= w_border;
      r_s1_fill   <= w_fill;
      r_s1_origin <= w_origin;
      for (int i = 0; i < NUM_FRAMES; i++) r_s1_color[i] <= w_color[i];
    end
  end

  // Stage 2 select: lowest-index border wins; fills only when no border hits
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
`ifdef FRAME_FILL_EN
    for (int i = NUM_FRAMES - 1; i >= 0; i--) begin
      if (r_s1_fill[i]) begin
        w_any = 1'b1;
        w_win = ~r_s1_color[i];
      end
    end
`endif
    for (int i = NUM_FRAMES - 1; i >= 0; i--) begin
      if (r_s1_border[i]) begin
        w_any = 1'b1;
        w_win = r_s1_color[i];
      end
    end
  end

  // Stage 2 output registers; colour holds when nothing is hit
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      RGB         <= '0;
      dav         <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      if (w_any) RGB <= w_win;
      dav         <= w_any;
      frame_start <= r_s1_origin;
    end
  end

endmodule

`default_nettype wire
